// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    localparam logic [1:0] PC_SEL_ADDER = 2'b00;
    localparam logic [1:0] PC_SEL_ID    = 2'b01;
    localparam logic [1:0] PC_SEL_HOLD  = 2'b10;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 33;

endpackage

// File: rtl/mdu_busy_timer.sv
// rtl/mdu_busy_timer.sv - MDU occupancy FSM with load/decrement counter and done pulse
module mdu_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
    input  logic       is_div,
    output logic       busy,
    output logic       done,
    output logic [5:0] cnt
);

    // Counter holds cycles remaining after the current one, so N busy cycles load N-1.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    mdu_state_t state;

    // Occupancy FSM: RUN accepts a new operation, MDU_BUSY counts down and emits done on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 6'd0;
            done  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    done <= 1'b0;
                    if (accept) begin
                        state <= MDU_BUSY;
                        cnt   <= is_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                MDU_BUSY: begin
                    if (cnt == 6'd0) begin
                        state <= RUN;
                        done  <= 1'b1;
                    end else begin
                        cnt  <= cnt - 6'd1;
                        done <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy = (state == MDU_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/redirect controller; optional stall counter under PIPE_STALL_CNT_EN
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rf_waddr,
    input  logic        id_branch_taken,
    input  logic        id_mdu_start,
    input  logic        id_mdu_div,
    input  logic        id_mdu_read,
    output logic [1:0]  if_pc_sel,
    output logic        if_id_hold,
    output logic        id_ex_bubble,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic        mdu_done
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    logic       ld_haz;
    logic       mdu_haz;
    logic       stall;
    logic       accept;
    logic [5:0] timer_cnt;

    // Hazard detection: a load writing a register the ID instruction reads, or an MDU conflict.
    always_comb begin
        ld_haz  = ex_is_load && (ex_rf_waddr != 5'd0) &&
                  ((id_uses_rs && (id_rs == ex_rf_waddr)) ||
                   (id_uses_rt && (id_rt == ex_rf_waddr)));
        mdu_haz = mdu_busy && (id_mdu_read || id_mdu_start);
        stall   = ld_haz || mdu_haz;
        // A start blocked by a load-use stall is simply retried once the stall clears.
        accept  = !mdu_busy && id_mdu_start && !ld_haz;
    end

    // Output muxing: a stall wins over a redirect so the held branch re-resolves next cycle.
    always_comb begin
        if_pc_sel    = PC_SEL_ADDER;
        if_id_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        if (stall) begin
            if_pc_sel    = PC_SEL_HOLD;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (id_branch_taken) begin
            if_pc_sel = PC_SEL_ID;
        end
        mdu_start = accept;
    end

    mdu_busy_timer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
        .is_div (id_mdu_div),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .cnt    (timer_cnt)
    );

`ifdef PIPE_STALL_CNT_EN
    // Saturating count of stalled cycles for performance monitoring.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rf_waddr;
    logic        id_uses_rs, id_uses_rt, ex_is_load, id_branch_taken;
    logic        id_mdu_start, id_mdu_div, id_mdu_read;
    logic [1:0]  if_pc_sel;
    logic        if_id_hold, id_ex_bubble, mdu_start, mdu_busy, mdu_done;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    pipe_hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_is_load      (ex_is_load),
        .ex_rf_waddr     (ex_rf_waddr),
        .id_branch_taken (id_branch_taken),
        .id_mdu_start    (id_mdu_start),
        .id_mdu_div      (id_mdu_div),
        .id_mdu_read     (id_mdu_read),
        .if_pc_sel       (if_pc_sel),
        .if_id_hold      (if_id_hold),
        .id_ex_bubble    (id_ex_bubble),
        .mdu_start       (mdu_start),
        .mdu_busy        (mdu_busy),
        .mdu_done        (mdu_done)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: cycles of MDU occupancy still ahead, pending done pulse, stall tally.
    int      m_busy_left = 0;
    bit      m_done      = 1'b0;
    longint  m_stalls    = 0;
    bit      model_valid = 1'b0;

    logic [1:0]  cap_pc_sel;
    logic        cap_hold, cap_bubble, cap_start, cap_busy, cap_done;
    logic [31:0] cap_stalls;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; ex_rf_waddr = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_is_load = 1'b0;
        id_branch_taken = 1'b0; id_mdu_start = 1'b0; id_mdu_div = 1'b0; id_mdu_read = 1'b0;
    endtask

    // Inputs are already applied; check at the falling edge, advance the model, return after the rising edge.
    task automatic cycle();
        bit         busy, ld, mh, st, acc;
        logic [1:0] exp_sel;
        @(negedge clk);
        busy = (m_busy_left > 0);
        ld   = ex_is_load && (ex_rf_waddr != 0) &&
               ((id_uses_rs && id_rs == ex_rf_waddr) || (id_uses_rt && id_rt == ex_rf_waddr));
        mh   = busy && (id_mdu_read || id_mdu_start);
        st   = ld || mh;
        acc  = !busy && id_mdu_start && !ld;
        exp_sel = st ? 2'd2 : (id_branch_taken ? 2'd1 : 2'd0);
        cap_pc_sel = if_pc_sel; cap_hold = if_id_hold; cap_bubble = id_ex_bubble;
        cap_start = mdu_start; cap_busy = mdu_busy; cap_done = mdu_done;
`ifdef PIPE_STALL_CNT_EN
        cap_stalls = stall_cycles;
`else
        cap_stalls = 32'd0;
`endif
        if (model_valid) begin
            chk("if_pc_sel", {30'd0, if_pc_sel}, {30'd0, exp_sel});
            chk("if_id_hold", {31'd0, if_id_hold}, {31'd0, st});
            chk("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, st});
            chk("mdu_start", {31'd0, mdu_start}, {31'd0, acc});
            chk("mdu_busy", {31'd0, mdu_busy}, {31'd0, busy});
            chk("mdu_done", {31'd0, mdu_done}, {31'd0, m_done});
`ifdef PIPE_STALL_CNT_EN
            chk("stall_cycles", stall_cycles, m_stalls[31:0]);
`endif
        end
        if (rst) begin
            m_busy_left = 0; m_done = 1'b0; m_stalls = 0; model_valid = 1'b1;
        end else begin
            if (st && m_stalls < 64'hFFFF_FFFF) m_stalls++;
            if (acc) begin
                m_busy_left = id_mdu_div ? DIV_N : MUL_N;
                m_done = 1'b0;
            end else if (m_busy_left > 0) begin
                m_busy_left--;
                m_done = (m_busy_left == 0);
            end else begin
                m_done = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    int done_seen;

    initial begin
        idle_inputs();
        #1;
        do_reset();

        // Reset state with idle inputs.
        cycle();
        chk("reset_busy", {31'd0, cap_busy}, 32'd0);
        chk("reset_done", {31'd0, cap_done}, 32'd0);
        chk("reset_pc_sel", {30'd0, cap_pc_sel}, 32'd0);
        chk("reset_cnt", {26'd0, dut.u_timer.cnt}, 32'd0);

        // Load-use hazard, one cycle, then load gone.
        ex_is_load = 1'b1; ex_rf_waddr = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        cycle();
        chk("lu_pc_sel", {30'd0, cap_pc_sel}, 32'd2);
        chk("lu_hold", {31'd0, cap_hold}, 32'd1);
        chk("lu_bubble", {31'd0, cap_bubble}, 32'd1);
        ex_is_load = 1'b0;
        cycle();
        chk("lu_after_pc_sel", {30'd0, cap_pc_sel}, 32'd0);

        // Load to $zero never stalls; branch redirects.
        ex_is_load = 1'b1; ex_rf_waddr = 5'd0; id_rs = 5'd0; id_branch_taken = 1'b1;
        cycle();
        chk("zero_pc_sel", {30'd0, cap_pc_sel}, 32'd1);
        chk("zero_hold", {31'd0, cap_hold}, 32'd0);

        // Multiply with a waiting reader.
        do_reset();
        id_mdu_start = 1'b1; id_mdu_div = 1'b0;
        cycle();
        chk("mul_start", {31'd0, cap_start}, 32'd1);
        id_mdu_start = 1'b0; id_mdu_read = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk("mul_busy", {31'd0, cap_busy}, 32'd1);
            chk("mul_stall", {30'd0, cap_pc_sel}, 32'd2);
        end
        cycle();
        chk("mul_done", {31'd0, cap_done}, 32'd1);
        chk("mul_nostall", {31'd0, cap_hold}, 32'd0);
`ifdef PIPE_STALL_CNT_EN
        chk("mul_stall_cycles", cap_stalls, 32'd4);
`endif
        idle_inputs();
        cycle();
        chk("mul_done_clear", {31'd0, cap_done}, 32'd0);

        // Divide abandoned by reset at T+10.
        done_seen = 0;
        id_mdu_start = 1'b1; id_mdu_div = 1'b1;
        cycle();
        idle_inputs();
        for (int i = 1; i <= 9; i++) begin
            cycle();
            if (cap_done) done_seen++;
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("div_rst_busy", {31'd0, cap_busy}, 32'd0);
        chk("div_rst_cnt", {26'd0, dut.u_timer.cnt}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (cap_done) done_seen++;
        end
        chk("div_rst_no_done", done_seen, 32'd0);

        // Second start plus branch while busy.
        id_mdu_start = 1'b1; id_mdu_div = 1'b0;
        cycle();
        id_branch_taken = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk("second_hold_sel", {30'd0, cap_pc_sel}, 32'd2);
        end
        cycle();
        chk("second_done", {31'd0, cap_done}, 32'd1);
        chk("second_start", {31'd0, cap_start}, 32'd1);
        chk("second_sel", {30'd0, cap_pc_sel}, 32'd1);
        idle_inputs();

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst             = ($urandom_range(0, 199) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rf_waddr     = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_is_load      = ($urandom_range(0, 3) == 0);
            id_branch_taken = ($urandom_range(0, 3) == 0);
            id_mdu_start    = ($urandom_range(0, 7) == 0);
            id_mdu_div      = ($urandom_range(0, 3) == 0);
            id_mdu_read     = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
